// File: rtl/dmux4_dispatcher_pkg.sv
// rtl/dmux4_dispatcher_pkg.sv - shared select codes, state encoding and rotation helper
package dmux4_dispatcher_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int DISP_CNT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // First ready consumer scanning from ptr; falls back to ptr when nobody is ready.
  function automatic logic [1:0] pick_target(input logic [1:0] ptr,
                                             input logic [3:0] rdy,
                                             input logic       skip);
    logic [1:0] idx;
    logic       found;
    pick_target = ptr;
    found       = 1'b0;
    if (skip) begin
      for (int i = 0; i < 4; i++) begin
        idx = ptr + 2'(i);
        if (!found && rdy[idx]) begin
          pick_target = idx;
          found       = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/dmux4_fanout.sv
// rtl/dmux4_fanout.sv - per-bit 4-way demultiplexers for held data and valid
module dmux4_way
  import dmux4_dispatcher_pkg::*;
(
  input  logic       in,
  input  logic [1:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d
);

  always_comb begin
    a = 1'b0;
    b = 1'b0;
    c = 1'b0;
    d = 1'b0;
    case (sel)
      SEL_A:   a = in;
      SEL_B:   b = in;
      SEL_C:   c = in;
      SEL_D:   d = in;
      default: a = 1'b0;
    endcase
  end

endmodule

module dmux4_fanout #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0]   data,
  input  logic               valid,
  input  logic [1:0]         sel,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dmux4_way u_way (
      .in  (data[g]),
      .sel (sel),
      .a   (out_data[g]),
      .b   (out_data[WIDTH+g]),
      .c   (out_data[2*WIDTH+g]),
      .d   (out_data[3*WIDTH+g])
    );
  end

  dmux4_way u_valid (
    .in  (valid),
    .sel (sel),
    .a   (out_valid[0]),
    .b   (out_valid[1]),
    .c   (out_valid[2]),
    .d   (out_valid[3])
  );

endmodule

// File: rtl/dmux4_dispatcher.sv
// rtl/dmux4_dispatcher.sv - one-deep holding register dispatched round-robin to four sinks
module dmux4_dispatcher
  import dmux4_dispatcher_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter bit SKIP_BUSY = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*WIDTH-1:0]    out_data,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [1:0]            sel,
  output logic                  busy,
  output logic [DISP_CNT_W-1:0] disp_cnt
);

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      hold_data_q, hold_data_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [DISP_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            target;
  logic                  hold_valid;
  logic                  fire;
  logic                  accept;

  assign hold_valid = (state_q == FULL);
  assign target     = pick_target(ptr_q, out_ready, SKIP_BUSY);
  assign fire       = hold_valid & out_ready[target] & ~flush;
  assign in_ready   = ~flush & (~hold_valid | fire);
  assign accept     = in_valid & in_ready;

  assign sel      = target;
  assign busy     = hold_valid;
  assign disp_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      hold_data_q <= '0;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  // A dispatch and a new accept in the same cycle keep the register FULL.
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (accept) begin
      state_d     = FULL;
      hold_data_d = in_data;
    end else if (fire || flush) begin
      state_d = EMPTY;
    end
    if (fire) begin
      ptr_d = target + 2'd1;
      cnt_d = cnt_q + DISP_CNT_W'(1);
    end
  end

  dmux4_fanout #(.WIDTH(WIDTH)) u_fanout (
    .data      (hold_data_q),
    .valid     (hold_valid),
    .sel       (target),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

endmodule
